pipeline_ctl: RTL and testbench

Sequencing controller for the decode→execute instruction register of the 8-bit CPU. It enables the PC and the instruction-register load each cycle. It inserts bubbles for load-use hazards and taken jumps, and freezes the pipeline while a data-memory access handshakes. It also keeps a saturating stall counter for debug.

---
 rtl/pipeline_ctl_pkg.sv | 34 +++
 rtl/pipeline_ctl_hazard_detect.sv | 32 +++
 rtl/pipeline_ctl.sv | 149 ++++++++++++++
 tb/tb_pipeline_ctl.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctl_pkg.sv
// Shared types for the decode->execute sequencing controller: FSM states, the NOP
// control word the instruction register takes on a bubble, and the source-match helper.
package pipeline_ctl_pkg;

  typedef enum logic [1:0] {
    StResetHold = 2'd0,
    StRun       = 2'd1,
    StMemWait   = 2'd2,
    StFlush     = 2'd3
  } ctl_state_e;

  localparam int unsigned RegAddrW  = 4;
  localparam int unsigned FlushCntW = 2;

  // Execute-stage control word held by the instruction register.
  typedef struct packed {
    logic reg_write;
    logic data_read;
    logic data_write;
    logic stack_push;
    logic stack_pop;
    logic jump;
  } ex_ctrl_t;

  // A bubble captures this: nothing writes, reads, touches the stack or jumps.
  localparam ex_ctrl_t NopCtrl = '0;

  function automatic logic src_match(input logic                uses,
                                     input logic [RegAddrW-1:0] src,
                                     input logic [RegAddrW-1:0] dst);
    return uses & (src == dst);
  endfunction

endpackage

// File: rtl/pipeline_ctl_hazard_detect.sv
// Load-use hazard compare between the decode sources and the load destination, either
// the one still in execute or the one whose read completed on the previous cycle.
module pipeline_ctl_hazard_detect
  import pipeline_ctl_pkg::*;
(
  input  logic [RegAddrW-1:0] a_addr_i,
  input  logic [RegAddrW-1:0] b_addr_i,
  input  logic                uses_a_i,
  input  logic                uses_b_i,
  input  logic [RegAddrW-1:0] c_addr_x_i,
  input  logic                data_read_x_i,
  input  logic                reg_write_x_i,
  input  logic                last_was_load_i,
  input  logic [RegAddrW-1:0] c_addr_load_i,
  output logic                hazard_o
);

  logic hit_x;
  logic hit_load;

  always_comb begin
    hit_x    = data_read_x_i & reg_write_x_i &
               (src_match(uses_a_i, a_addr_i, c_addr_x_i) |
                src_match(uses_b_i, b_addr_i, c_addr_x_i));
    // Latched path: the load's destination captured when its read was acked.
    hit_load = last_was_load_i &
               (src_match(uses_a_i, a_addr_i, c_addr_load_i) |
                src_match(uses_b_i, b_addr_i, c_addr_load_i));
    hazard_o = hit_x | hit_load;
  end

endmodule

// File: rtl/pipeline_ctl.sv
// Decode->execute sequencing controller: PC/IR enables, bubbles for load-use and taken
// jumps, freeze during data-memory handshakes, and a saturating debug stall counter.
module pipeline_ctl
  import pipeline_ctl_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned CNT_W        = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [RegAddrW-1:0] a_addr_d,
  input  logic [RegAddrW-1:0] b_addr_d,
  input  logic                uses_a_d,
  input  logic                uses_b_d,
  input  logic [RegAddrW-1:0] c_addr_x,
  input  logic                reg_write_x,
  input  logic                data_read_x,
  input  logic                data_write_x,
  input  logic                jump_taken_x,
  input  logic                mem_ack,
  output logic                pc_en,
  output logic                ir_load,
  output logic                ir_bubble,
  output logic                mem_req,
  output logic                busy,
  output logic [CNT_W-1:0]    stall_count
);

  localparam logic [FlushCntW-1:0] FlushInit = FlushCntW'(FLUSH_CYCLES - 1);

  ctl_state_e           state_q, state_d;
  logic [FlushCntW-1:0] flush_cnt_q, flush_cnt_d;
  logic [CNT_W-1:0]     stall_count_q, stall_count_d;
  logic                 access_done_q, access_done_d;
  logic                 last_was_load_q, last_was_load_d;
  logic [RegAddrW-1:0]  c_addr_q, c_addr_d;

  logic hazard;
  logic mem_pending;
  logic mem_done;

  pipeline_ctl_hazard_detect u_hazard_detect (
    .a_addr_i        (a_addr_d),
    .b_addr_i        (b_addr_d),
    .uses_a_i        (uses_a_d),
    .uses_b_i        (uses_b_d),
    .c_addr_x_i      (c_addr_x),
    .data_read_x_i   (data_read_x),
    .reg_write_x_i   (reg_write_x),
    .last_was_load_i (last_was_load_q),
    .c_addr_load_i   (c_addr_q),
    .hazard_o        (hazard)
  );

  // The IR still holds a memory instruction for one cycle after its ack; don't reissue it.
  assign mem_pending = (data_read_x | data_write_x) & ~access_done_q;
  assign mem_done    = mem_req & mem_ack;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= StResetHold;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      StResetHold: state_d = StRun;
      StRun: begin
        if (mem_pending) begin
          if (!mem_ack) state_d = StMemWait;
        end else if (jump_taken_x && (FLUSH_CYCLES > 1)) begin
          state_d     = StFlush;
          flush_cnt_d = FlushInit;
        end
      end
      StMemWait: begin
        if (mem_ack) state_d = StRun;
      end
      StFlush: begin
        flush_cnt_d = flush_cnt_q - 1'b1;
        if (flush_cnt_q == 2'd1) state_d = StRun;
      end
      default: state_d = StResetHold;
    endcase
  end

  always_comb begin
    pc_en     = 1'b0;
    ir_load   = 1'b0;
    ir_bubble = 1'b0;
    mem_req   = 1'b0;
    unique case (state_q)
      StResetHold: ir_bubble = 1'b1;
      StRun: begin
        if (mem_pending) begin
          mem_req = 1'b1;
        end else if (jump_taken_x) begin
          pc_en     = 1'b1;
          ir_bubble = 1'b1;
        end else if (hazard) begin
          ir_bubble = 1'b1;
        end else begin
          pc_en   = 1'b1;
          ir_load = 1'b1;
        end
      end
      StMemWait: mem_req = 1'b1;
      StFlush: begin
        pc_en     = 1'b1;
        ir_bubble = 1'b1;
      end
      default: ir_bubble = 1'b1;
    endcase
  end

  assign busy        = (state_q != StRun);
  assign stall_count = stall_count_q;

  always_comb begin
    access_done_d   = mem_done;
    last_was_load_d = mem_done & data_read_x & reg_write_x;
    c_addr_d        = mem_done ? c_addr_x : c_addr_q;
    stall_count_d   = stall_count_q;
    if ((state_q != StResetHold) && !pc_en && (stall_count_q != '1)) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      flush_cnt_q     <= '0;
      stall_count_q   <= '0;
      access_done_q   <= 1'b0;
      last_was_load_q <= 1'b0;
      c_addr_q        <= '0;
    end else begin
      flush_cnt_q     <= flush_cnt_d;
      stall_count_q   <= stall_count_d;
      access_done_q   <= access_done_d;
      last_was_load_q <= last_was_load_d;
      c_addr_q        <= c_addr_d;
    end
  end

endmodule

// File: tb/tb_pipeline_ctl.sv
// Bench for pipeline_ctl: directed scenarios plus randomized traffic against a
// cycle-level behavioural model of the controller's rules.
module tb_pipeline_ctl;

  localparam int unsigned FC     = 2;
  localparam int unsigned CW     = 4;
  localparam int          CntMax = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [3:0]    a_addr_d = '0;
  logic [3:0]    b_addr_d = '0;
  logic [3:0]    c_addr_x = '0;
  logic          uses_a_d = 1'b0;
  logic          uses_b_d = 1'b0;
  logic          reg_write_x = 1'b0;
  logic          data_read_x = 1'b0;
  logic          data_write_x = 1'b0;
  logic          jump_taken_x = 1'b0;
  logic          mem_ack = 1'b0;
  logic          pc_en;
  logic          ir_load;
  logic          ir_bubble;
  logic          mem_req;
  logic          busy;
  logic [CW-1:0] stall_count;

  int checks = 0;
  int failures = 0;

  // Model: reset hold, outstanding access, access already served, bubbles left after
  // a jump, destination of a load acked last cycle (-1 if none), stall cycles.
  bit            m_hold;
  bit            m_wait;
  bit            m_done;
  int            m_flush;
  int            m_load;
  int            m_stalls;
  logic [4:0]    exp_out;  // {pc_en, ir_load, ir_bubble, mem_req, busy}
  logic [CW-1:0] exp_cnt;

  always #5 clk = ~clk;

  pipeline_ctl #(.FLUSH_CYCLES(FC), .CNT_W(CW)) dut (
    .CLK          (clk),
    .RST          (rst),
    .a_addr_d     (a_addr_d),
    .b_addr_d     (b_addr_d),
    .uses_a_d     (uses_a_d),
    .uses_b_d     (uses_b_d),
    .c_addr_x     (c_addr_x),
    .reg_write_x  (reg_write_x),
    .data_read_x  (data_read_x),
    .data_write_x (data_write_x),
    .jump_taken_x (jump_taken_x),
    .mem_ack      (mem_ack),
    .pc_en        (pc_en),
    .ir_load      (ir_load),
    .ir_bubble    (ir_bubble),
    .mem_req      (mem_req),
    .busy         (busy),
    .stall_count  (stall_count)
  );

  function automatic logic [4:0] obs();
    return {pc_en, ir_load, ir_bubble, mem_req, busy};
  endfunction

  function automatic void model_reset();
    m_hold   = 1'b1;
    m_wait   = 1'b0;
    m_done   = 1'b0;
    m_flush  = 0;
    m_load   = -1;
    m_stalls = 0;
  endfunction

  function automatic void model_outputs();
    bit haz;
    haz = (m_load >= 0) && ((uses_a_d && int'(a_addr_d) == m_load) ||
                            (uses_b_d && int'(b_addr_d) == m_load));
    if (m_hold)                                      exp_out = 5'b00101;
    else if (m_wait)                                 exp_out = 5'b00011;
    else if (m_flush > 0)                            exp_out = 5'b10101;
    else if ((data_read_x || data_write_x) && !m_done) exp_out = 5'b00010;
    else if (jump_taken_x)                           exp_out = 5'b10100;
    else if (haz)                                    exp_out = 5'b00100;
    else                                             exp_out = 5'b11000;
    exp_cnt = CW'(m_stalls);
  endfunction

  function automatic void model_step();
    bit completed;
    completed = 1'b0;
    if (rst) begin
      model_reset();
      return;
    end
    if (m_hold) begin
      m_hold = 1'b0;
      return;
    end
    if (!exp_out[4] && m_stalls < CntMax) m_stalls++;
    if (m_wait) begin
      if (mem_ack) begin
        m_wait    = 1'b0;
        completed = 1'b1;
      end
    end else if (m_flush > 0) begin
      m_flush--;
    end else if ((data_read_x || data_write_x) && !m_done) begin
      if (mem_ack) completed = 1'b1;
      else m_wait = 1'b1;
    end else if (jump_taken_x) begin
      m_flush = FC - 1;
    end
    m_done = completed;
    m_load = (completed && data_read_x && reg_write_x) ? int'(c_addr_x) : -1;
  endfunction

  task automatic settle();
    @(negedge clk);
    model_outputs();
  endtask

  task automatic advance();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic clear_inputs();
    a_addr_d = '0; b_addr_d = '0; c_addr_x = '0;
    uses_a_d = 1'b0; uses_b_d = 1'b0; reg_write_x = 1'b0;
    data_read_x = 1'b0; data_write_x = 1'b0; jump_taken_x = 1'b0; mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) rst = 1'b0;
      settle();
      checks++;
      if (obs() !== exp_out || stall_count !== exp_cnt) begin
        failures++;
        $display("FAIL reset_hold cyc%0d got=%b/%0d want=%b/%0d", i, obs(), stall_count,
                 exp_out, exp_cnt);
      end
      advance();
    end
    settle();
    checks++;
    if (pc_en !== 1'b1 || ir_load !== 1'b1 || ir_bubble !== 1'b0 || stall_count !== '0) begin
      failures++;
      $display("FAIL reset_release got pc_en=%b ir_load=%b ir_bubble=%b cnt=%0d want 1 1 0 0",
               pc_en, ir_load, ir_bubble, stall_count);
    end
    advance();
  endtask

  task automatic test_load_use();
    int base;
    int bubbles;
    base = m_stalls;
    bubbles = 0;
    data_read_x = 1'b1; reg_write_x = 1'b1; c_addr_x = 4'd5; mem_ack = 1'b1;
    uses_a_d = 1'b1; a_addr_d = 4'd5;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) mem_ack = 1'b0;
      if (i == 2) begin
        data_read_x = 1'b0; reg_write_x = 1'b0; c_addr_x = '0;
      end
      settle();
      checks++;
      if (obs() !== exp_out || stall_count !== exp_cnt) begin
        failures++;
        $display("FAIL load_use cyc%0d got=%b/%0d want=%b/%0d", i, obs(), stall_count,
                 exp_out, exp_cnt);
      end
      if (ir_bubble === 1'b1) bubbles++;
      advance();
    end
    checks++;
    if (bubbles != 1) begin
      failures++;
      $display("FAIL load_use_bubbles got=%0d want=1", bubbles);
    end
    checks++;
    if (int'(stall_count) != base + 2) begin
      failures++;
      $display("FAIL load_use_stalls got=%0d want=%0d", stall_count, base + 2);
    end
    clear_inputs();
  endtask

  task automatic test_mem_wait();
    int req_cyc;
    int stall_cyc;
    int hold_cyc;
    req_cyc = 0; stall_cyc = 0; hold_cyc = 0;
    data_write_x = 1'b1;
    for (int i = 0; i < 5; i++) begin
      mem_ack = (i == 3);
      settle();
      checks++;
      if (obs() !== exp_out || stall_count !== exp_cnt) begin
        failures++;
        $display("FAIL mem_wait cyc%0d got=%b/%0d want=%b/%0d", i, obs(), stall_count,
                 exp_out, exp_cnt);
      end
      if (mem_req === 1'b1) req_cyc++;
      if (pc_en === 1'b0) stall_cyc++;
      if (ir_load === 1'b0 && ir_bubble === 1'b0) hold_cyc++;
      if (i == 4) begin
        checks++;
        if (busy !== 1'b0 || ir_load !== 1'b1) begin
          failures++;
          $display("FAIL mem_wait_resume got busy=%b ir_load=%b want 0 1", busy, ir_load);
        end
      end
      advance();
    end
    checks++;
    if (req_cyc != 4 || stall_cyc != 4 || hold_cyc != 4) begin
      failures++;
      $display("FAIL mem_wait_counts got req=%0d stall=%0d hold=%0d want 4 4 4",
               req_cyc, stall_cyc, hold_cyc);
    end
    clear_inputs();
  endtask

  task automatic test_jump();
    int flush_cyc;
    flush_cyc = 0;
    for (int i = 0; i < 4; i++) begin
      jump_taken_x = (i == 0);
      settle();
      checks++;
      if (obs() !== exp_out || stall_count !== exp_cnt) begin
        failures++;
        $display("FAIL jump cyc%0d got=%b/%0d want=%b/%0d", i, obs(), stall_count,
                 exp_out, exp_cnt);
      end
      if (pc_en === 1'b1 && ir_bubble === 1'b1) flush_cyc++;
      if (i == 2) begin
        checks++;
        if (ir_load !== 1'b1 || busy !== 1'b0) begin
          failures++;
          $display("FAIL jump_resume got ir_load=%b busy=%b want 1 0", ir_load, busy);
        end
      end
      advance();
    end
    checks++;
    if (flush_cyc != FC) begin
      failures++;
      $display("FAIL jump_bubbles got=%0d want=%0d", flush_cyc, FC);
    end
    clear_inputs();
  endtask

  task automatic test_priority();
    data_read_x = 1'b1; reg_write_x = 1'b1; c_addr_x = 4'd3; jump_taken_x = 1'b1;
    uses_a_d = 1'b1; a_addr_d = 4'd3;
    for (int i = 0; i < 6; i++) begin
      mem_ack = (i == 2);
      if (i == 4) begin
        data_read_x = 1'b0; reg_write_x = 1'b0; jump_taken_x = 1'b0; a_addr_d = 4'd7;
      end
      settle();
      checks++;
      if (obs() !== exp_out || stall_count !== exp_cnt) begin
        failures++;
        $display("FAIL priority cyc%0d got=%b/%0d want=%b/%0d", i, obs(), stall_count,
                 exp_out, exp_cnt);
      end
      if (i == 3) begin
        checks++;
        if (pc_en !== 1'b1 || ir_bubble !== 1'b1 || mem_req !== 1'b0) begin
          failures++;
          $display("FAIL priority_jump got pc_en=%b ir_bubble=%b mem_req=%b want 1 1 0",
                   pc_en, ir_bubble, mem_req);
        end
      end
      if (i == 5) begin
        checks++;
        if (ir_load !== 1'b1) begin
          failures++;
          $display("FAIL priority_no_hazard got ir_load=%b want 1", ir_load);
        end
      end
      advance();
    end
    clear_inputs();
  endtask

  task automatic load_random_instr();
    int kind;
    kind = $urandom_range(0, 9);
    clear_inputs();
    c_addr_x = 4'($urandom_range(0, 3));
    case (kind)
      0, 1: begin data_read_x = 1'b1; reg_write_x = 1'b1; end
      2: data_write_x = 1'b1;
      3: jump_taken_x = 1'b1;
      4: begin data_read_x = 1'b1; reg_write_x = 1'b1; jump_taken_x = 1'b1; end
      5: ;
      default: reg_write_x = 1'b1;
    endcase
  endtask

  task automatic test_random();
    logic [4:0] cyc_out;
    clear_inputs();
    for (int i = 0; i < 400; i++) begin
      a_addr_d = 4'($urandom_range(0, 3));
      b_addr_d = 4'($urandom_range(0, 3));
      uses_a_d = 1'($urandom_range(0, 1));
      uses_b_d = 1'($urandom_range(0, 1));
      mem_ack  = ($urandom_range(0, 4) < 2);
      settle();
      checks++;
      if (obs() !== exp_out || stall_count !== exp_cnt) begin
        failures++;
        $display("FAIL random cyc%0d got=%b/%0d want=%b/%0d", i, obs(), stall_count,
                 exp_out, exp_cnt);
      end
      cyc_out = exp_out;
      advance();
      // Emulate the instruction register feeding execute.
      if (cyc_out[3]) begin
        load_random_instr();
      end else if (cyc_out[2]) begin
        data_read_x = 1'b0; data_write_x = 1'b0; reg_write_x = 1'b0; jump_taken_x = 1'b0;
      end
    end
    clear_inputs();
  endtask

  task automatic test_saturation_reset();
    rst = 1'b1;
    model_reset();
    advance();
    rst = 1'b0;
    advance();
    data_write_x = 1'b1;
    for (int i = 0; i < 20; i++) begin
      settle();
      checks++;
      if (obs() !== exp_out || stall_count !== exp_cnt) begin
        failures++;
        $display("FAIL saturate cyc%0d got=%b/%0d want=%b/%0d", i, obs(), stall_count,
                 exp_out, exp_cnt);
      end
      advance();
    end
    checks++;
    if (stall_count !== 4'd15) begin
      failures++;
      $display("FAIL saturate_value got=%0d want=15", stall_count);
    end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    model_outputs();
    checks++;
    if (mem_req !== 1'b0 || stall_count !== '0 || obs() !== exp_out) begin
      failures++;
      $display("FAIL async_reset got mem_req=%b cnt=%0d outs=%b want 0 0 %b", mem_req,
               stall_count, obs(), exp_out);
    end
    clear_inputs();
    advance();
    rst = 1'b0;
    advance();
  endtask

  initial begin
    model_reset();
    exp_out = '0;
    exp_cnt = '0;
    test_reset();
    test_load_use();
    test_mem_wait();
    test_jump();
    test_priority();
    test_random();
    test_saturation_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
